camera_state_ctrl: RTL and testbench

// - Top-level capture sequencer for the pixel array: on Init, runs Erase -> Expose -> row-by-row Readout -> Done.
// - Exposure length taken from the 5-bit EX_time (ms units) produced by the exposure-time controller.
// - Drives the array control lines (Erase, Expose, NRE per row, ADC); one capture per Init, then back to idle.

---
 rtl/camera_state_ctrl_pkg.sv | 35 +++
 rtl/camera_state_ctrl_if.sv | 39 +++
 rtl/camera_state_ctrl_phase_counter.sv | 39 +++
 rtl/camera_state_ctrl.sv | 165 ++++++++++++++++
 tb/tb_camera_state_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/camera_state_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// camera_pkg
// Shared types and constants for the camera capture sequencer.
//   state_e  : top-level capture FSM states
//   phase_e  : per-row readout phase (settle / sample / hold)
//   EX_*     : exposure-time width and clamp range (ms units)
//   clamp_ex : limits a raw exposure request to [EX_MIN, EX_MAX]
// -----------------------------------------------------------------------------
package camera_pkg;

  localparam int             EX_W   = 5;
  localparam logic [EX_W-1:0] EX_MIN = 5'd2;
  localparam logic [EX_W-1:0] EX_MAX = 5'd30;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    READOUT = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } phase_e;

  function automatic logic [EX_W-1:0] clamp_ex(input logic [EX_W-1:0] ex);
    if (ex < EX_MIN)      return EX_MIN;
    else if (ex > EX_MAX) return EX_MAX;
    else                  return ex;
  endfunction

endpackage

// File: rtl/camera_state_ctrl_if.sv
// -----------------------------------------------------------------------------
// camera_state_ctrl_if
// Start request, exposure setting and pixel-array control lines of the
// capture sequencer.
//   Init     : start request (master -> slave)
//   EX_time  : exposure time in ms units (master -> slave)
//   Erase    : pixel erase, active-high
//   Expose   : pixel exposure, active-high
//   NRE      : per-row read enable, active-low, at most one bit low
//   ADC      : ADC sample strobe, active-high
//   Busy     : capture in progress
//   Done     : one-cycle end-of-capture pulse
// The slave modport is the sequencer; the master modport is its client.
// -----------------------------------------------------------------------------
interface camera_state_ctrl_if #(
  parameter int ROWS = 2
);
  import camera_pkg::*;

  logic            Init;
  logic [EX_W-1:0] EX_time;
  logic            Erase;
  logic            Expose;
  logic [ROWS-1:0] NRE;
  logic            ADC;
  logic            Busy;
  logic            Done;

  modport master (
    output Init, EX_time,
    input  Erase, Expose, NRE, ADC, Busy, Done
  );

  modport slave (
    input  Init, EX_time,
    output Erase, Expose, NRE, ADC, Busy, Done
  );

endinterface

// File: rtl/camera_state_ctrl_phase_counter.sv
// -----------------------------------------------------------------------------
// cam_phase_counter
// Loadable down-counter that times the erase, expose and readout phases.
//   i_clk      : clock, posedge
//   i_rst_n    : synchronous reset, active-low (clears count)
//   i_load     : load i_load_val (has priority over i_en)
//   i_en       : decrement by one; holds at zero
//   i_load_val : value loaded on i_load
//   o_count    : current count
//   o_zero     : count is zero (terminal count of the phase)
// -----------------------------------------------------------------------------
module cam_phase_counter #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_count = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/camera_state_ctrl.sv
// -----------------------------------------------------------------------------
// camera_state_ctrl
// Capture sequencer for the pixel array. On Init it runs
// Erase -> Expose -> row-by-row Readout -> Done, then returns to idle.
//   Clk   : system clock, posedge
//   Reset : synchronous reset, active-low
//   bus   : camera_state_ctrl_if.slave (Init, EX_time in; array controls out)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for Init; latches clamped EX_time on start
//   ERASE   | Erase high for ERASE_CYCLES cycles
//   EXPOSE  | Expose high for EX_lat*CYCLES_PER_MS cycles
//   READOUT | per row: P0 settle, P1 ADC strobe, P2 hold (NRE[row] low)
//   DONE    | one-cycle Done pulse, Busy still high
//
// Outputs decode only registered state, row and phase count, so there is no
// combinational path from Init/EX_time to any output.
// -----------------------------------------------------------------------------
module camera_state_ctrl
  import camera_pkg::*;
#(
  parameter int CYCLES_PER_MS = 1,
  parameter int ERASE_CYCLES  = 2,
  parameter int ROWS          = 2
) (
  input logic               Clk,
  input logic               Reset,
  camera_state_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_ERASE   = ERASE;
  localparam logic [2:0] S_EXPOSE  = EXPOSE;
  localparam logic [2:0] S_READOUT = READOUT;
  localparam logic [2:0] S_DONE    = DONE;

  localparam int EXP_MAX_CYC = int'(EX_MAX) * CYCLES_PER_MS;
  localparam int CNT_MAX_A   = (EXP_MAX_CYC > ERASE_CYCLES) ? EXP_MAX_CYC : ERASE_CYCLES;
  localparam int CNT_MAX     = (CNT_MAX_A > 3) ? CNT_MAX_A : 3;
  localparam int CNT_W       = $clog2(CNT_MAX) + 1;
  localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Readout phase count starts at 2 and runs down: 2=P0, 1=P1, 0=P2.
  localparam logic [CNT_W-1:0] ROW_LOAD   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [EX_W-1:0]  r_ex_lat;
  logic [ROW_W-1:0] r_row;
  logic             w_last_row;
  logic             w_load;
  logic             w_en;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_count;
  logic             w_zero;
  logic [CNT_W-1:0] w_expose_load;
  phase_e           w_phase;
  logic [ROWS-1:0]  w_nre;

  cam_phase_counter #(
    .W(CNT_W)
  ) u_phase_cnt (
    .i_clk     (Clk),
    .i_rst_n   (Reset),
    .i_load    (w_load),
    .i_en      (w_en),
    .i_load_val(w_load_val),
    .o_count   (w_count),
    .o_zero    (w_zero)
  );

  assign w_last_row    = (r_row == ROW_W'(ROWS - 1));
  assign w_expose_load = CNT_W'(int'(r_ex_lat) * CYCLES_PER_MS - 1);

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.Init) begin
          w_next     = S_ERASE;
          w_load     = 1'b1;
          w_load_val = ERASE_LOAD;
        end
      end
      S_ERASE: begin
        if (w_zero) begin
          w_next     = S_EXPOSE;
          w_load     = 1'b1;
          w_load_val = w_expose_load;
        end else begin
          w_en = 1'b1;
        end
      end
      S_EXPOSE: begin
        if (w_zero) begin
          w_next     = S_READOUT;
          w_load     = 1'b1;
          w_load_val = ROW_LOAD;
        end else begin
          w_en = 1'b1;
        end
      end
      S_READOUT: begin
        if (w_zero) begin
          if (w_last_row) begin
            w_next = S_DONE;
          end else begin
            // Next row's P0 follows P2 directly, no gap cycle.
            w_load     = 1'b1;
            w_load_val = ROW_LOAD;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_ex_lat <= EX_MIN;
      r_row    <= '0;
    end else begin
      r_state <= w_next;
      // Exposure is frozen at start so later EX_time changes cannot disturb a capture.
      if ((r_state == S_IDLE) && bus.Init) begin
        r_ex_lat <= clamp_ex(bus.EX_time);
      end
      if (r_state == S_IDLE) begin
        r_row <= '0;
      end else if ((r_state == S_READOUT) && w_zero && !w_last_row) begin
        r_row <= r_row + ROW_W'(1);
      end
    end
  end

  always_comb begin
    w_phase = P2;
    if (w_count == CNT_W'(2))      w_phase = P0;
    else if (w_count == CNT_W'(1)) w_phase = P1;
  end

  always_comb begin
    w_nre = '1;
    if (r_state == S_READOUT) begin
      w_nre[r_row] = 1'b0;
    end
  end

  assign bus.Erase  = (r_state == S_ERASE);
  assign bus.Expose = (r_state == S_EXPOSE);
  assign bus.ADC    = (r_state == S_READOUT) && (w_phase == P1);
  assign bus.NRE    = w_nre;
  assign bus.Busy   = (r_state != S_IDLE);
  assign bus.Done   = (r_state == S_DONE);

endmodule

// File: tb/tb_camera_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_camera_state_ctrl
// Drives two sequencer instances (1 clk/ms with 2 rows, 4 clk/ms with 4 rows)
// and compares every cycle against a reference that expands each accepted
// capture into its list of expected output vectors.
// Vector layout: {Erase, Expose, ADC, Busy, Done, NRE[3:0]} (NRE padded with 1s).
// -----------------------------------------------------------------------------
module tb_camera_state_ctrl;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  camera_state_ctrl_if #(.ROWS(2)) bus_a ();
  camera_state_ctrl_if #(.ROWS(4)) bus_b ();

  camera_state_ctrl #(
    .CYCLES_PER_MS(1),
    .ERASE_CYCLES (2),
    .ROWS         (2)
  ) dut_a (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus_a.slave)
  );

  camera_state_ctrl #(
    .CYCLES_PER_MS(4),
    .ERASE_CYCLES (2),
    .ROWS         (4)
  ) dut_b (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus_b.slave)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         sel         = 0;
  bit         m_idle      = 1'b1;
  logic [8:0] q[$];
  logic [8:0] last_obs;

  function automatic logic [8:0] vec(input bit e, input bit x, input bit a,
                                     input bit b, input bit d, input logic [3:0] n);
    return {e, x, a, b, d, n};
  endfunction

  // Expand one accepted capture into the cycle-by-cycle expected outputs.
  task automatic start_model(input logic [4:0] ex);
    int lat, cpm, rows;
    logic [3:0] n;
    cpm  = (sel == 0) ? 1 : 4;
    rows = (sel == 0) ? 2 : 4;
    lat  = (ex < 2) ? 2 : ((ex > 30) ? 30 : int'(ex));
    repeat (2) q.push_back(vec(1, 0, 0, 1, 0, 4'hF));
    repeat (lat * cpm) q.push_back(vec(0, 1, 0, 1, 0, 4'hF));
    for (int r = 0; r < rows; r++) begin
      n = 4'hF;
      n[r] = 1'b0;
      for (int p = 0; p < 3; p++) q.push_back(vec(0, 0, (p == 1), 1, 0, n));
    end
    q.push_back(vec(0, 0, 0, 1, 1, 4'hF));
  endtask

  function automatic logic [8:0] observe();
    if (sel == 0)
      return {bus_a.Erase, bus_a.Expose, bus_a.ADC, bus_a.Busy, bus_a.Done, 2'b11, bus_a.NRE};
    else
      return {bus_b.Erase, bus_b.Expose, bus_b.ADC, bus_b.Busy, bus_b.Done, bus_b.NRE};
  endfunction

  task automatic step(input bit init, input logic [4:0] ex, input bit rst, input string tag);
    logic [8:0] exp_v;
    logic [8:0] obs;
    @(negedge Clk);
    Reset         = rst;
    bus_a.Init    = (sel == 0) && init;
    bus_b.Init    = (sel == 1) && init;
    bus_a.EX_time = ex;
    bus_b.EX_time = ex;
    @(posedge Clk);
    if (!rst) q.delete();
    else if (m_idle && init) start_model(ex);
    #1;
    if (q.size() > 0) begin
      exp_v  = q.pop_front();
      m_idle = 1'b0;
    end else begin
      exp_v  = vec(0, 0, 0, 0, 0, 4'hF);
      m_idle = 1'b1;
    end
    obs      = observe();
    last_obs = obs;
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp_v);
    end
  endtask

  task automatic run_idle(input logic [4:0] ex, input string tag);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 500) begin
      step(1'b0, ex, 1'b1, tag);
      guard++;
    end
    vectors++;
    assert (guard < 500) else begin
      miscompares++;
      $error("FAIL %s_timeout observed=%0d expected=<500", tag, guard);
    end
  endtask

  task automatic run_capture(input logic [4:0] ex, input string tag);
    step(1'b1, ex, 1'b1, tag);
    run_idle(ex, tag);
    step(1'b0, ex, 1'b1, tag);
  endtask

  initial begin
    logic [4:0] ex;
    bit         init;
    bit         rst;
    int         dones;
    int         guard;

    Reset         = 1'b0;
    bus_a.Init    = 1'b0;
    bus_b.Init    = 1'b0;
    bus_a.EX_time = '0;
    bus_b.EX_time = '0;

    // Reset state, Init ignored while in reset.
    repeat (2) step(1'b0, 5'd10, 1'b0, "reset");
    step(1'b1, 5'd10, 1'b0, "reset_init");
    step(1'b0, 5'd10, 1'b1, "idle");

    // Nominal capture and exposure clamp boundaries.
    run_capture(5'd10, "ex10");
    run_capture(5'd1,  "ex1");
    run_capture(5'd31, "ex31");
    run_capture(5'd0,  "ex0");
    run_capture(5'd2,  "ex2");
    run_capture(5'd30, "ex30");

    // EX_time change during EXPOSE does not affect the running capture.
    step(1'b1, 5'd10, 1'b1, "exchg");
    repeat (6) step(1'b0, 5'd10, 1'b1, "exchg");
    run_idle(5'd20, "exchg");
    step(1'b0, 5'd20, 1'b1, "exchg");
    run_capture(5'd20, "ex20");

    // Init pulses while busy are ignored; exactly one Done.
    step(1'b1, 5'd6, 1'b1, "busy_init");
    dones = 0;
    guard = 0;
    while (q.size() > 0 && guard < 500) begin
      init = 1'($urandom_range(0, 1));
      step(init, 5'($urandom_range(0, 31)), 1'b1, "busy_init");
      if (last_obs[4]) dones++;
      guard++;
    end
    vectors++;
    assert (dones == 1) else begin
      miscompares++;
      $error("FAIL busy_init_dones observed=%0d expected=1", dones);
    end
    step(1'b0, 5'd6, 1'b1, "busy_init");

    // Init held high: back-to-back captures with one idle cycle between.
    repeat (60) step(1'b1, 5'd7, 1'b1, "held");
    run_idle(5'd7, "held");
    step(1'b0, 5'd7, 1'b1, "held");

    // Reset at EXPOSE cycle 5 abandons the capture; then a clean capture.
    step(1'b1, 5'd10, 1'b1, "midrst");
    repeat (5) step(1'b0, 5'd10, 1'b1, "midrst");
    step(1'b0, 5'd10, 1'b0, "midrst");
    repeat (3) step(1'b0, 5'd10, 1'b1, "midrst_idle");
    run_capture(5'd10, "after_rst");

    // Randomized captures with random EX_time, Init noise and rare resets.
    repeat (25) begin
      ex = 5'($urandom_range(0, 31));
      step(1'b1, ex, 1'b1, "rand");
      guard = 0;
      while (q.size() > 0 && guard < 500) begin
        if ($urandom_range(0, 7) == 0) ex = 5'($urandom_range(0, 31));
        init = 1'($urandom_range(0, 1));
        rst  = ($urandom_range(0, 59) != 0);
        step(init, ex, rst, "rand");
        guard++;
      end
      repeat ($urandom_range(1, 3)) step(1'b0, ex, 1'b1, "rand_gap");
    end

    // Second instance: 4 clk per ms, 4 rows.
    sel = 1;
    step(1'b0, 5'd3, 1'b1, "b_idle");
    run_capture(5'd3, "b_ex3");
    run_capture(5'd0, "b_ex0");
    repeat (4) begin
      ex = 5'($urandom_range(0, 31));
      step(1'b1, ex, 1'b1, "b_rand");
      guard = 0;
      while (q.size() > 0 && guard < 500) begin
        init = 1'($urandom_range(0, 1));
        step(init, 5'($urandom_range(0, 31)), 1'b1, "b_rand");
        guard++;
      end
      step(1'b0, ex, 1'b1, "b_gap");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
